// File: rtl/mac_pe.sv
// mac_pe -- sign-magnitude multiply-accumulate processing element for a
// weight-stationary systolic CNN array.
//
// Each PE holds one weight loaded through a daisy-chained prefetch path,
// multiplies the incoming activation by that weight and adds the product to
// the partial sum arriving from the upstream PE.
//
// Ports:
//   clk      in   clock, all state updates on the rising edge
//   rst      in   synchronous active-high reset
//   A_en     in   activation valid, triggers one MAC
//   A_ready  out  registered copy of A_en
//   A_in     in   activation, sign + Q7.8 magnitude
//   A_out    out  registered activation forwarded to the neighbouring PE
//   W_en     in   weight-chain valid
//   W_ready  out  weight register loaded
//   W_in     in   weight-chain input, sign + Q1.6 magnitude
//   W_out    out  weight-chain output to the next PE (combinational pass-through)
//   P_in     in   upstream partial sum, sign + Q25.14 magnitude
//   P_out    out  registered partial sum
//
// Configuration macro: MAC_SATURATION_EN
//   defined   -> result magnitudes above the format range clamp to full scale
//   undefined -> result magnitude wraps modulo 2^(P_BITWIDTH-1)

module mac_pe #(
  parameter int A_BITWIDTH = 16,
  parameter int W_BITWIDTH = 8,
  parameter int P_BITWIDTH = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  A_en,
  output logic                  A_ready,
  input  logic [A_BITWIDTH-1:0] A_in,
  output logic [A_BITWIDTH-1:0] A_out,
  input  logic                  W_en,
  output logic                  W_ready,
  input  logic [W_BITWIDTH-1:0] W_in,
  output logic [W_BITWIDTH-1:0] W_out,
  input  logic [P_BITWIDTH-1:0] P_in,
  output logic [P_BITWIDTH-1:0] P_out
);

  // Magnitude widths of each operand and of the product.
  localparam int AM    = A_BITWIDTH - 1;
  localparam int WM    = W_BITWIDTH - 1;
  localparam int PM    = P_BITWIDTH - 1;
  localparam int PRODW = AM + WM;
  // One extra bit over the partial sum so the sum of two full-scale
  // magnitudes of either sign is representable in two's complement.
  localparam int TCW   = P_BITWIDTH + 1;

  localparam logic [TCW-1:0] TC_ONE = {{(TCW-1){1'b0}}, 1'b1};

  logic [W_BITWIDTH-1:0] weight_r;
  logic                  w_ready_r;
  logic                  a_ready_r;
  logic [A_BITWIDTH-1:0] a_out_r;
  logic [P_BITWIDTH-1:0] p_out_r;

  logic [PRODW-1:0]      prod_mag_s;
  logic [PM-1:0]         prod_ext_s;
  logic                  prod_sign_s;
  logic [TCW-1:0]        sum_s;
  logic [P_BITWIDTH-1:0] mac_result_s;
  logic                  load_s;

  // Sign-magnitude to two's complement; a negative zero maps to zero.
  function automatic logic [TCW-1:0] sm_to_tc(input logic sign,
                                               input logic [PM-1:0] mag);
    logic [TCW-1:0] ext;
    ext = {2'b00, mag};
    return sign ? (~ext + TC_ONE) : ext;
  endfunction

  // Two's complement back to sign-magnitude, with range handling and
  // zero normalization (a zero magnitude is always reported as positive).
  function automatic logic [P_BITWIDTH-1:0] tc_to_sm(input logic [TCW-1:0] sum);
    logic           sign;
    logic [TCW-1:0] abs_val;
    logic [PM-1:0]  mag;
    sign    = sum[TCW-1];
    abs_val = sign ? (~sum + TC_ONE) : sum;
`ifdef MAC_SATURATION_EN
    // Any bit above the magnitude field means the result is out of range.
    mag = (|abs_val[TCW-1:PM]) ? {PM{1'b1}} : abs_val[PM-1:0];
`else
    mag = abs_val[PM-1:0];
`endif
    return {sign & (|mag), mag};
  endfunction

  // MAC datapath: product of magnitudes, signed add, conversion back.
  always_comb begin
    prod_mag_s   = {{WM{1'b0}}, A_in[AM-1:0]} * {{AM{1'b0}}, weight_r[WM-1:0]};
    prod_ext_s   = {{(PM-PRODW){1'b0}}, prod_mag_s};
    prod_sign_s  = A_in[AM] ^ weight_r[WM];
    sum_s        = sm_to_tc(P_in[PM], P_in[PM-1:0]) + sm_to_tc(prod_sign_s, prod_ext_s);
    mac_result_s = tc_to_sm(sum_s);
    load_s       = W_en & ~w_ready_r;
  end

  // Pipeline registers and the one-shot weight load.
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_r  <= {W_BITWIDTH{1'b0}};
      w_ready_r <= 1'b0;
      a_ready_r <= 1'b0;
      a_out_r   <= {A_BITWIDTH{1'b0}};
      p_out_r   <= {P_BITWIDTH{1'b0}};
    end else begin
      a_ready_r <= A_en;
      if (A_en) begin
        a_out_r <= A_in;
        p_out_r <= mac_result_s;
      end
      // The MAC above reads weight_r before this update takes effect.
      if (load_s) begin
        weight_r  <= W_in;
        w_ready_r <= 1'b1;
      end
    end
  end

  assign A_ready = a_ready_r;
  assign A_out   = a_out_r;
  assign P_out   = p_out_r;
  assign W_ready = w_ready_r;
  // Once loaded, this PE forwards the chain so later weights reach the next PE.
  assign W_out   = w_ready_r ? W_in : {W_BITWIDTH{1'b0}};

endmodule

// File: tb/tb_mac_pe.sv
// Testbench for mac_pe: three PEs chained on the weight path and the
// partial-sum path, checked every cycle against a behavioural model.
module tb_mac_pe;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_en;
  logic [7:0]  w_in;
  logic [39:0] p_in0;
  logic        a_en [3];
  logic [15:0] a_in [3];

  logic        a_ready [3];
  logic [15:0] a_out   [3];
  logic        w_ready [3];
  logic [7:0]  w_out   [3];
  logic [39:0] p_out   [3];
  logic        w_en1, w_en2;

  assign w_en1 = w_en  & w_ready[0];
  assign w_en2 = w_en1 & w_ready[1];

  always #5 clk = ~clk;

  mac_pe u_pe0 (.clk(clk), .rst(rst), .A_en(a_en[0]), .A_ready(a_ready[0]),
                .A_in(a_in[0]), .A_out(a_out[0]), .W_en(w_en), .W_ready(w_ready[0]),
                .W_in(w_in), .W_out(w_out[0]), .P_in(p_in0), .P_out(p_out[0]));
  mac_pe u_pe1 (.clk(clk), .rst(rst), .A_en(a_en[1]), .A_ready(a_ready[1]),
                .A_in(a_in[1]), .A_out(a_out[1]), .W_en(w_en1), .W_ready(w_ready[1]),
                .W_in(w_out[0]), .W_out(w_out[1]), .P_in(p_out[0]), .P_out(p_out[1]));
  mac_pe u_pe2 (.clk(clk), .rst(rst), .A_en(a_en[2]), .A_ready(a_ready[2]),
                .A_in(a_in[2]), .A_out(a_out[2]), .W_en(w_en2), .W_ready(w_ready[2]),
                .W_in(w_out[1]), .W_out(w_out[2]), .P_in(p_out[1]), .P_out(p_out[2]));

  int total = 0;
  int bad   = 0;

  // Behavioural model state (m_*) and next state (n_*).
  logic [7:0]  m_w[3],    n_w[3];
  logic        m_wr[3],   n_wr[3];
  logic        m_ardy[3], n_ardy[3];
  logic [15:0] m_aout[3], n_aout[3];
  logic [39:0] m_pout[3], n_pout[3];
  logic        model_valid = 1'b0;

  localparam longint MAXM = 64'h7F_FFFF_FFFF;

  // Signed-magnitude MAC computed with plain integer arithmetic.
  function automatic logic [39:0] ref_mac(logic [39:0] p, logic [15:0] a, logic [7:0] w);
    longint pv, pr, s, mag;
    logic   sg;
    pv = longint'(p[38:0]);
    if (p[39]) pv = -pv;
    pr = longint'(a[14:0]) * longint'(w[6:0]);
    if (a[15] ^ w[7]) pr = -pr;
    s   = pv + pr;
    sg  = (s < 0);
    mag = sg ? -s : s;
`ifdef MAC_SATURATION_EN
    if (mag > MAXM) mag = MAXM;
`else
    mag = mag % (MAXM + 1);
`endif
    if (mag == 0) sg = 1'b0;
    return {sg, mag[38:0]};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Weight each stage sees on its W_in given the current load state.
  function automatic logic [7:0] stage_win(int i);
    logic [7:0] v;
    v = w_in;
    for (int k = 0; k < i; k++) v = m_wr[k] ? v : 8'h00;
    return v;
  endfunction

  task automatic compare_model();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("a_ready%0d", i), a_ready[i], m_ardy[i]);
      chk($sformatf("a_out%0d", i),   a_out[i],   m_aout[i]);
      chk($sformatf("p_out%0d", i),   p_out[i],   m_pout[i]);
      chk($sformatf("w_ready%0d", i), w_ready[i], m_wr[i]);
      chk($sformatf("w_out%0d", i),   w_out[i],   stage_win(i + 1));
    end
  endtask

  task automatic compute_next();
    logic wen;
    wen = w_en;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        n_w[i] = 8'h00; n_wr[i] = 1'b0; n_ardy[i] = 1'b0;
        n_aout[i] = 16'h0000; n_pout[i] = 40'h0;
      end else begin
        n_ardy[i] = a_en[i];
        n_aout[i] = a_en[i] ? a_in[i] : m_aout[i];
        n_pout[i] = a_en[i] ? ref_mac((i == 0) ? p_in0 : m_pout[i-1], a_in[i], m_w[i])
                            : m_pout[i];
        n_w[i]  = (wen && !m_wr[i]) ? stage_win(i) : m_w[i];
        n_wr[i] = m_wr[i] | wen;
      end
      wen = wen & m_wr[i];
    end
  endtask

  // One clock: compare at the falling edge, advance the model with the edge.
  task automatic cycle();
    @(negedge clk);
    if (model_valid) compare_model();
    compute_next();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      m_w[i] = n_w[i]; m_wr[i] = n_wr[i]; m_ardy[i] = n_ardy[i];
      m_aout[i] = n_aout[i]; m_pout[i] = n_pout[i];
    end
    if (rst) model_valid = 1'b1;
    #1;
  endtask

  task automatic idle();
    w_en = 1'b0;
    for (int i = 0; i < 3; i++) a_en[i] = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  logic [39:0] save_p;
  logic [15:0] save_a;
  logic [63:0] r64;

  initial begin
    rst = 1'b1; w_en = 1'b0; w_in = 8'h00; p_in0 = 40'h0;
    for (int i = 0; i < 3; i++) begin a_en[i] = 1'b0; a_in[i] = 16'h0000; end
    do_reset();
    chk("reset_p_out0", p_out[0], 40'h0);
    chk("reset_w_out0", w_out[0], 8'h00);

    // Weight chain fill.
    w_en = 1'b1;
    w_in = 8'h7C; cycle();
    w_in = 8'hB2; cycle();
    w_in = 8'hF8; cycle();
    w_en = 1'b0; w_in = 8'h5A;
    #1;
    chk("chain_w_ready", {w_ready[2], w_ready[1], w_ready[0]}, 3'b111);
    chk("chain_w_out2", w_out[2], 8'h5A);
    chk("model_w0", m_w[0], 8'h7C);
    chk("model_w1", m_w[1], 8'hB2);
    chk("model_w2", m_w[2], 8'hF8);

    // Systolic accumulate down the chain.
    a_en[0] = 1'b1; a_in[0] = 16'h0DB9; p_in0 = 40'h0; cycle(); a_en[0] = 1'b0;
    chk("sys_p0", p_out[0], 40'd435612);
    chk("sys_p0_model", m_pout[0], 40'd435612);
    chk("sys_a0", a_out[0], 16'h0DB9);
    a_en[1] = 1'b1; a_in[1] = 16'h07E3; cycle(); a_en[1] = 1'b0;
    chk("sys_p1", p_out[1], 40'd334662);
    chk("sys_p1_model", m_pout[1], 40'd334662);
    chk("sys_a1", a_out[1], 16'h07E3);
    a_en[2] = 1'b1; a_in[2] = 16'h07E7; cycle(); a_en[2] = 1'b0;
    chk("sys_p2", p_out[2], 40'h00_0001_66FE);
    chk("sys_p2_model", m_pout[2], 40'h00_0001_66FE);
    chk("sys_a2", a_out[2], 16'h07E7);

    // Hold for three idle cycles, then reset.
    save_p = p_out[2]; save_a = a_out[2];
    a_in[2] = 16'h1234;
    repeat (3) cycle();
    chk("hold_p2", p_out[2], save_p);
    chk("hold_a2", a_out[2], save_a);
    chk("hold_ardy2", a_ready[2], 1'b0);
    do_reset();
    chk("rst_p2", p_out[2], 40'h0);
    chk("rst_a2", a_out[2], 16'h0000);
    chk("rst_w_ready", {w_ready[2], w_ready[1], w_ready[0]}, 3'b000);

    // Unloaded weight: partial sum passes through, negative zero normalized.
    a_en[0] = 1'b1; a_in[0] = 16'h7FFF; p_in0 = 40'h80_0000_0000; cycle();
    chk("noweight_negzero", p_out[0], 40'h0);
    p_in0 = 40'h12_3456_789A; cycle(); a_en[0] = 1'b0;
    chk("noweight_pass", p_out[0], 40'h12_3456_789A);

    // Sign crossing with weight -1.0.
    do_reset();
    w_en = 1'b1; w_in = 8'hC0; cycle(); w_en = 1'b0;
    a_en[0] = 1'b1; a_in[0] = 16'h0100; p_in0 = 40'h0; cycle(); a_en[0] = 1'b0;
    chk("sign_cross", p_out[0], 40'h80_0000_4000);

    // Overflow then negative zero with weight +1.0.
    do_reset();
    w_en = 1'b1; w_in = 8'h40; cycle(); w_en = 1'b0;
    a_en[0] = 1'b1; a_in[0] = 16'h0100; p_in0 = 40'h7F_FFFF_FFFF; cycle();
`ifdef MAC_SATURATION_EN
    chk("overflow", p_out[0], 40'h7F_FFFF_FFFF);
`else
    chk("overflow", p_out[0], 40'h00_0000_3FFF);
`endif
    p_in0 = 40'h80_0000_4000; cycle(); a_en[0] = 1'b0;
    chk("neg_zero", p_out[0], 40'h00_0000_0000);

    // Randomized episodes, checked every cycle by the model.
    for (int ep = 0; ep < 12; ep++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        rst  = ($urandom_range(0, 99) == 0);
        w_en = ($urandom_range(0, 3) == 0);
        w_in = 8'($urandom());
        for (int i = 0; i < 3; i++) begin
          a_en[i] = $urandom_range(0, 1) == 1;
          a_in[i] = 16'($urandom());
        end
        r64 = {$urandom(), $urandom()};
        case ($urandom_range(0, 3))
          0:       p_in0 = {r64[39], 39'h7F_FFFF_0000 | {23'h0, r64[15:0]}};
          1:       p_in0 = {r64[39], 39'h0};
          default: p_in0 = r64[39:0];
        endcase
        cycle();
      end
      rst = 1'b0;
    end
    idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
